shift_sequencer: RTL

Multi-cycle shift controller that shares one iterative shift datapath between two requesters, for example the ALU issue path and the address/immediate path. It arbitrates round-robin and performs SLL, SRL or SRA by processing one bit of the shift amount per cycle, so each operation takes a fixed latency. It returns the result with a valid/ready handshake and a requester tag. It sits beside the ALU and replaces per-bit combinational shift muxing on the critical path.

---
 rtl/shift_pkg.sv | 7 +
 rtl/shift_stage.sv | 20 ++
 rtl/shift_sequencer.sv | 87 ++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared widths, shift opcodes and sequencer states
package shift_pkg;
  localparam int XLEN_DEF = 64;
  localparam int SHW_DEF = 6;
  typedef enum logic [1:0] {SLL = 2'b00, SRL = 2'b01, RSV = 2'b10, SRA = 2'b11} shift_op_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one conditional shift by 2^k with op-specific fill
module shift_stage
  import shift_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int SHW = SHW_DEF
) (
  input  logic [XLEN-1:0] acc,
  input  shift_op_t       op,
  input  logic            en,
  input  logic [SHW-1:0]  k,
  output logic [XLEN-1:0] out
);
  logic [SHW-1:0] amt;
  logic [XLEN-1:0] sra;
  assign amt = SHW'(1) << k;
  assign sra = $signed(acc) >>> amt;
  // select the shifted accumulator, or pass it through when disabled or reserved
  always_comb out = !en ? acc : op == SLL ? acc << amt : op == SRL ? acc >> amt : op == SRA ? sra : acc;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: round-robin shared iterative shifter with valid/ready response
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int SHW = SHW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [1:0]      req0_op,
  input  logic [XLEN-1:0] req0_data,
  input  logic [SHW-1:0]  req0_shamt,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [1:0]      req1_op,
  input  logic [XLEN-1:0] req1_data,
  input  logic [SHW-1:0]  req1_shamt,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_id,
  output logic            busy
);
  seq_state_t state;
  shift_op_t op;
  logic [SHW-1:0] k, shamt;
  logic [XLEN-1:0] acc, stage_out;
  logic id, prio, gnt, take;
  assign gnt = req0_valid && req1_valid ? prio : req1_valid;
  assign take = rst_n && state == IDLE && (req0_valid || req1_valid);
  assign req0_ready = take && !gnt;
  assign req1_ready = take && gnt;
  shift_stage #(.XLEN(XLEN), .SHW(SHW)) u_stage (
    .acc(acc),
    .op(op),
    .en(shamt[k]),
    .k(k),
    .out(stage_out)
  );
  // sequencer: accept a grant, run one shift stage per cycle, hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op <= SLL;
      k <= '0;
      shamt <= '0;
      acc <= '0;
      id <= 1'b0;
      prio <= 1'b0;
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_id <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (take) begin
          op <= shift_op_t'(gnt ? req1_op : req0_op);
          acc <= gnt ? req1_data : req0_data;
          shamt <= gnt ? req1_shamt : req0_shamt;
          id <= gnt;
          prio <= !gnt;
          k <= '0;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          acc <= stage_out;
          k <= k + 1'b1;
          if (k == SHW'(SHW - 1)) begin
            resp_valid <= 1'b1;
            resp_data <= stage_out;
            resp_id <= id;
            state <= DONE;
          end
        end
        DONE: if (resp_ready) begin
          resp_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
